a_line_packer: RTL

//  Downstream stage of the A-line acquisition block. Collects the 14-bit A-line samples of one sweep

---
 rtl/a_line_pkg.sv | 16 +
 rtl/a_line_bank_ram.sv | 26 ++
 rtl/a_line_packer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/a_line_pkg.sv
// rtl/a_line_pkg.sv - shared widths, FSM state types and line geometry for the A-line packer
package a_line_pkg;

    localparam int SAMPLE_W = 14;
    localparam int LANES = 4;
    localparam int WORD_W = 64;
    localparam logic [15:0] HDR_MAGIC = 16'hA11E;

    typedef enum logic [1:0] {C_IDLE, C_FILL, C_COMMIT} cap_state_t;
    typedef enum logic [1:0] {R_IDLE, R_HDR, R_DATA} rd_state_t;

    function automatic int words_per_line(input int n);
        return (n + LANES - 1) / LANES;
    endfunction

endpackage

// File: rtl/a_line_bank_ram.sv
// rtl/a_line_bank_ram.sv - simple dual-port line RAM holding both ping-pong banks, 1-cycle registered read
module a_line_bank_ram #(
    parameter int DEPTH = 586,
    parameter int AW    = 10,
    parameter int DW    = 64
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/a_line_packer.sv
// rtl/a_line_packer.sv - captures one sweep of samples into ping-pong banks and streams it as 64-bit words
// Define A_LINE_PACKER_HEADER_EN to prefix every line with a header word.
module a_line_packer
    import a_line_pkg::*;
#(
    parameter int NSAMPLES = 1170,
    parameter int LCNT_W   = 16
) (
    input  logic                clk_system,
    input  logic                global_reset,
    input  logic                enable,
    input  logic                sweep_trigger,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    output logic [WORD_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_sop,
    output logic                out_eop,
    output logic                capturing,
    output logic [LCNT_W-1:0]   line_count,
    output logic                overrun
);
    localparam int W  = words_per_line(NSAMPLES);
    localparam int AW = $clog2(2 * W);
    localparam int IW = $clog2(W + 1);
    localparam int CW = $clog2(NSAMPLES);
    localparam bit PAD = (NSAMPLES % LANES) != 0;
`ifdef A_LINE_PACKER_HEADER_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif

    cap_state_t cap_state, cap_state_n;
    rd_state_t rd_state, rd_state_n;
    logic trig_d1, trigger, start, drop, commit;
    logic wr_bank, rd_bank;
    logic [1:0] full, set_vec, clr_vec, full_now;
    logic [CW-1:0] samp_cnt;
    logic [SAMPLE_W-1:0] lane0, lane1, lane2;
    logic [LCNT_W-1:0] bank_seq [2];
    logic we, re, issue, issue_hdr, acc, eop_acc, room;
    logic [AW-1:0] waddr, raddr, wr_base;
    logic [WORD_W-1:0] wdata, rdata, hdr_word, pend_data;
    logic [IW-1:0] rd_idx;
    logic [1:0] occ;
    logic pend_valid, pend_hdr, pend_sop, pend_eop;
    logic skid_valid, skid_sop, skid_eop;
    logic [WORD_W-1:0] skid_data;

    assign trigger   = sweep_trigger & ~trig_d1;
    assign capturing = (cap_state == C_FILL);
    assign set_vec   = commit ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
    assign clr_vec   = eop_acc ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;
    assign full_now  = full | set_vec;
    assign wr_base   = wr_bank ? AW'(W) : '0;

    always_comb begin
        cap_state_n = cap_state;
        start  = 1'b0;
        drop   = 1'b0;
        commit = 1'b0;
        case (cap_state)
            C_IDLE: if (trigger && enable) begin
                if (full[wr_bank]) drop = 1'b1;
                else begin
                    start = 1'b1;
                    cap_state_n = C_FILL;
                end
            end
            C_FILL: if (sample_valid && samp_cnt == CW'(NSAMPLES - 1)) cap_state_n = C_COMMIT;
            C_COMMIT: begin
                commit = 1'b1;
                cap_state_n = C_IDLE;
            end
            default: cap_state_n = C_IDLE;
        endcase
    end

    // Full words are written as lane 3 arrives; a partial last word is flushed during COMMIT.
    always_comb begin
        we = 1'b0;
        waddr = '0;
        wdata = '0;
        if (cap_state == C_FILL && sample_valid && samp_cnt[1:0] == 2'd3) begin
            we = 1'b1;
            waddr = wr_base + AW'(samp_cnt[CW-1:2]);
            wdata = {16'(sample_in), 16'(lane2), 16'(lane1), 16'(lane0)};
        end else if (commit && PAD) begin
            we = 1'b1;
            waddr = wr_base + AW'(W - 1);
            wdata = {16'h0000, 16'(lane2), 16'(lane1), 16'(lane0)};
        end
    end

    always_ff @(posedge clk_system or negedge global_reset) begin
        if (!global_reset) begin
            cap_state   <= C_IDLE;
            trig_d1     <= 1'b0;
            wr_bank     <= 1'b0;
            samp_cnt    <= '0;
            lane0       <= '0;
            lane1       <= '0;
            lane2       <= '0;
            line_count  <= '0;
            overrun     <= 1'b0;
            bank_seq[0] <= '0;
            bank_seq[1] <= '0;
            full        <= '0;
        end else begin
            trig_d1   <= sweep_trigger;
            cap_state <= cap_state_n;
            if (start) begin
                samp_cnt <= '0;
                lane0 <= '0;
                lane1 <= '0;
                lane2 <= '0;
            end else if (cap_state == C_FILL && sample_valid) begin
                samp_cnt <= samp_cnt + 1'b1;
                case (samp_cnt[1:0])
                    2'd0: lane0 <= sample_in;
                    2'd1: lane1 <= sample_in;
                    2'd2: lane2 <= sample_in;
                    default: begin
                        lane0 <= '0;
                        lane1 <= '0;
                        lane2 <= '0;
                    end
                endcase
            end
            if (drop) overrun <= 1'b1;
            if (commit) begin
                wr_bank <= ~wr_bank;
                line_count <= line_count + LCNT_W'(1);
                bank_seq[wr_bank] <= line_count + LCNT_W'(1);
            end
            full <= (full | set_vec) & ~clr_vec;
        end
    end

    // Items in flight (RAM read + output + skid) never exceed two, so the skid cannot overflow.
    assign acc     = out_valid & out_ready;
    assign eop_acc = acc & out_eop;
    assign occ     = 2'(out_valid) + 2'(skid_valid) + 2'(pend_valid) - 2'(acc);
    assign room    = (occ < 2'd2);

    always_comb begin
        rd_state_n = rd_state;
        issue = 1'b0;
        issue_hdr = 1'b0;
        case (rd_state)
            R_IDLE: if (full_now[rd_bank]) rd_state_n = HDR_EN ? R_HDR : R_DATA;
            R_HDR: if (room) begin
                issue = 1'b1;
                issue_hdr = 1'b1;
                rd_state_n = R_DATA;
            end
            R_DATA: begin
                if (room && rd_idx != IW'(W)) issue = 1'b1;
                if (eop_acc) rd_state_n = R_IDLE;
            end
            default: rd_state_n = R_IDLE;
        endcase
    end

    assign re        = issue & ~issue_hdr;
    assign raddr     = (rd_bank ? AW'(W) : '0) + AW'(rd_idx);
    assign hdr_word  = {HDR_MAGIC, 16'(NSAMPLES), 16'(bank_seq[rd_bank]), 16'h0000};
    assign pend_data = pend_hdr ? hdr_word : rdata;

    always_ff @(posedge clk_system or negedge global_reset) begin
        if (!global_reset) begin
            rd_state <= R_IDLE;
            rd_bank  <= 1'b0;
            rd_idx   <= '0;
        end else begin
            rd_state <= rd_state_n;
            if (eop_acc) rd_bank <= ~rd_bank;
            if (rd_state == R_IDLE) rd_idx <= '0;
            else if (re) rd_idx <= rd_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_system or negedge global_reset) begin
        if (!global_reset) begin
            pend_valid <= 1'b0;
            pend_hdr   <= 1'b0;
            pend_sop   <= 1'b0;
            pend_eop   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sop    <= 1'b0;
            out_eop    <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_sop   <= 1'b0;
            skid_eop   <= 1'b0;
        end else begin
            pend_valid <= issue;
            pend_hdr   <= issue_hdr;
            pend_sop   <= issue_hdr || (!HDR_EN && rd_idx == '0);
            pend_eop   <= !issue_hdr && rd_idx == IW'(W - 1);
            if (!out_valid || acc) begin
                if (skid_valid) begin
                    out_valid  <= 1'b1;
                    out_data   <= skid_data;
                    out_sop    <= skid_sop;
                    out_eop    <= skid_eop;
                    skid_valid <= pend_valid;
                    skid_data  <= pend_data;
                    skid_sop   <= pend_sop;
                    skid_eop   <= pend_eop;
                end else begin
                    out_valid <= pend_valid;
                    if (pend_valid) begin
                        out_data <= pend_data;
                        out_sop  <= pend_sop;
                        out_eop  <= pend_eop;
                    end
                end
            end else if (pend_valid) begin
                skid_valid <= 1'b1;
                skid_data  <= pend_data;
                skid_sop   <= pend_sop;
                skid_eop   <= pend_eop;
            end
        end
    end

    a_line_bank_ram #(
        .DEPTH(2 * W),
        .AW   (AW),
        .DW   (WORD_W)
    ) u_bank_ram (
        .clk  (clk_system),
        .we   (we),
        .waddr(waddr),
        .wdata(wdata),
        .re   (re),
        .raddr(raddr),
        .rdata(rdata)
    );

endmodule
